// File: rtl/dec_pkg.sv
// Shared types, constants and helpers for the scanning one-hot decoder.
package dec_pkg;

  // Widest select supported; onehot() returns this many output bits.
  localparam int unsigned MaxN    = 6;
  localparam int unsigned MaxOuts = 2 ** MaxN;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StDec,
    StScan,
    StPause
  } state_e;

  // Caller truncates the result to its own output count.
  function automatic logic [MaxOuts-1:0] onehot(input logic [MaxN-1:0] idx);
    return MaxOuts'(1) << idx;
  endfunction

endpackage

// File: rtl/dec_prescaler.sv
// Dwell counter for scan mode: counts 0..div_i, then wraps and flags terminal count.
module dec_prescaler #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tc_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // >= so that lowering div_i below the current count steps on the next cycle.
  assign tc_o = (cnt_q >= div_i);

  // Next count: clear wins, otherwise advance and wrap at terminal count; hold when idle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = tc_o ? '0 : cnt_q + DIV_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dec_scan_n.sv
// Registered N-to-2^N one-hot decoder with dual enables and an auto-scan mode.
module dec_scan_n
  import dec_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned DIV_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              E1,
  input  logic              E0_L,
  input  logic              MODE,
  input  logic [N-1:0]      X,
  input  logic [DIV_W-1:0]  DIV,
  output logic [2**N-1:0]   Y,
  output logic [N-1:0]      IDX,
  output logic              VALID,
  output logic              WRAP
);

  localparam int unsigned    OUTS    = 2 ** N;
  localparam logic [N-1:0]   LastIdx = N'(OUTS - 1);

  state_e            state_q, state_d;
  logic [N-1:0]      idx_q, idx_d;
  logic [OUTS-1:0]   y_q, y_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;
  logic              en, scan_req, out_on;
  logic              pre_clr, pre_adv, pre_tc;

  assign en       = E1 & ~E0_L;
  assign scan_req = (MODE == MODE_SCAN);

  dec_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (pre_clr),
    .adv_i (pre_adv),
    .div_i (DIV),
    .tc_o  (pre_tc)
  );

  // Next state, next index and next registered outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    pre_clr = 1'b0;
    pre_adv = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          idx_d   = X;
          state_d = scan_req ? StScan : StDec;
          pre_clr = scan_req;
        end
      end
      StDec: begin
        if (!en) begin
          state_d = StIdle;
        end else begin
          idx_d = X;
          if (scan_req) begin
            state_d = StScan;
            pre_clr = 1'b1;
          end
        end
      end
      StScan: begin
        // Every cycle spent showing an index counts toward its dwell, including
        // the cycle in which the enable drops, so a pause resumes with the remainder.
        pre_adv = 1'b1;
        if (pre_tc) idx_d = idx_q + N'(1);
        if (!en) begin
          state_d = StPause;
        end else if (!scan_req) begin
          state_d = StDec;
          idx_d   = X;
        end else begin
          wrap_d = pre_tc && (idx_q == LastIdx);
        end
      end
      StPause: begin
        if (en) begin
          if (scan_req) begin
            state_d = StScan;
          end else begin
            state_d = StDec;
            idx_d   = X;
          end
        end else if (!scan_req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    out_on  = (state_d == StDec) || (state_d == StScan);
    y_d     = out_on ? OUTS'(onehot(MaxN'(idx_d))) : '0;
    valid_d = out_on;
  end

  // State, index and output registers; reset overrides all inputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      idx_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Y     = y_q;
  assign IDX   = idx_q;
  assign VALID = valid_q;
  assign WRAP  = wrap_q;

endmodule

// File: tb/tb_dec_scan_n.sv
// Bench for dec_scan_n: an N=2 and an N=3 instance share stimulus and are
// compared every cycle against a behavioural model, plus directed scenarios.
module tb_dec_scan_n;

  localparam int PIdle  = 0;
  localparam int PDec   = 1;
  localparam int PScan  = 2;
  localparam int PPause = 3;

  typedef struct {
    int phase;
    int idx;
    int el;
    int y;
    int valid;
    int wrap;
  } mdl_t;

  logic       CLK;
  logic       rst, e1, e0l, mode;
  logic [2:0] x;
  logic [7:0] div;

  logic [3:0] y2;
  logic [1:0] idx2;
  logic       valid2, wrap2;
  logic [7:0] y3;
  logic [2:0] idx3;
  logic       valid3, wrap3;

  int   n_cmp = 0;
  int   n_err = 0;
  mdl_t m2, m3;

  dec_scan_n #(.N(2), .DIV_W(8)) u_dut2 (
    .CLK   (CLK),
    .RST   (rst),
    .E1    (e1),
    .E0_L  (e0l),
    .MODE  (mode),
    .X     (x[1:0]),
    .DIV   (div),
    .Y     (y2),
    .IDX   (idx2),
    .VALID (valid2),
    .WRAP  (wrap2)
  );

  dec_scan_n #(.N(3), .DIV_W(8)) u_dut3 (
    .CLK   (CLK),
    .RST   (rst),
    .E1    (e1),
    .E0_L  (e0l),
    .MODE  (mode),
    .X     (x),
    .DIV   (div),
    .Y     (y3),
    .IDX   (idx3),
    .VALID (valid3),
    .WRAP  (wrap3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Spec-level model: the current index is shown for div+1 displayed scan cycles.
  function automatic mdl_t mstep(input mdl_t m, input int outs, input int xin);
    mdl_t r;
    int   nidx, nel;
    bit   stp, en;
    r      = m;
    r.wrap = 0;
    if (rst) begin
      r.phase = PIdle;
      r.idx   = 0;
      r.el    = 0;
    end else begin
      en = e1 && !e0l;
      case (m.phase)
        PIdle: if (en) begin
          r.idx   = xin;
          r.el    = 0;
          r.phase = mode ? PScan : PDec;
        end
        PDec: if (!en) r.phase = PIdle;
        else begin
          r.idx = xin;
          if (mode) begin
            r.phase = PScan;
            r.el    = 0;
          end
        end
        PScan: begin
          stp  = m.el >= int'(div);
          nidx = stp ? (m.idx + 1) % outs : m.idx;
          nel  = stp ? 0 : m.el + 1;
          if (!en) begin
            r.phase = PPause;
            r.idx   = nidx;
            r.el    = nel;
          end else if (!mode) begin
            r.phase = PDec;
            r.idx   = xin;
          end else begin
            r.idx  = nidx;
            r.el   = nel;
            r.wrap = (stp && m.idx == outs - 1) ? 1 : 0;
          end
        end
        PPause: if (en) begin
          if (mode) r.phase = PScan;
          else begin
            r.phase = PDec;
            r.idx   = xin;
          end
        end else if (!mode) r.phase = PIdle;
        default: r.phase = PIdle;
      endcase
    end
    r.valid = (r.phase == PDec || r.phase == PScan) ? 1 : 0;
    r.y     = r.valid ? (1 << r.idx) : 0;
    return r;
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge CLK);
    m2 = mstep(m2, 4, int'(x[1:0]));
    m3 = mstep(m3, 8, int'(x));
    #1;
    check("y2", 64'(y2), 64'(m2.y));
    check("idx2", 64'(idx2), 64'(m2.idx));
    check("valid2", 64'(valid2), 64'(m2.valid));
    check("wrap2", 64'(wrap2), 64'(m2.wrap));
    check("y3", 64'(y3), 64'(m3.y));
    check("idx3", 64'(idx3), 64'(m3.idx));
    check("valid3", 64'(valid3), 64'(m3.valid));
    check("wrap3", 64'(wrap3), 64'(m3.wrap));
    if (valid2 !== (|y2)) check("valid2_eq_or_y2", 64'(valid2), 64'(|y2));
  endtask

  initial begin
    logic [3:0] exp_y [9];
    rst = 1'b1; e1 = 1'b1; e0l = 1'b0; mode = 1'b0; x = 3'd3; div = 8'd0;

    // Reset held for two cycles with the decoder enabled.
    repeat (2) begin
      tick();
      check("rst_y", 64'(y2), 64'd0);
      check("rst_idx", 64'(idx2), 64'd0);
    end

    // Decode truth table, then each enable disqualifies.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x = 3'(i);
      tick();
      check("dec_truth", 64'(y2), 64'(1) << i);
    end
    e0l = 1'b1;
    tick();
    check("dec_e0l_off", 64'(y2), 64'd0);
    e0l = 1'b0; e1 = 1'b0;
    tick();
    check("dec_e1_off", 64'(y2), 64'd0);

    // Scan from index 2 with a three-cycle dwell.
    exp_y = '{4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000,
              4'b0001, 4'b0001, 4'b0001};
    e1 = 1'b1; mode = 1'b1; div = 8'd2; x = 3'd2;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("scan_y", 64'(y2), 64'(exp_y[i]));
      check("scan_wrap", 64'(wrap2), 64'(i == 6));
    end

    // DIV=0 on the N=3 instance: index steps every cycle, wrap every 8.
    rst = 1'b1;
    tick();
    rst = 1'b0; div = 8'd0; x = 3'd0;
    for (int i = 0; i < 17; i++) begin
      tick();
      check("fast_idx3", 64'(idx3), 64'(i % 8));
      check("fast_wrap3", 64'(wrap3), 64'(i > 0 && i % 8 == 0));
    end

    // Pause with count=1 at index 1, DIV=2: one remaining dwell cycle on resume.
    rst = 1'b1;
    tick();
    rst = 1'b0; div = 8'd2; x = 3'd0;
    repeat (5) tick();
    check("pre_pause_idx", 64'(idx2), 64'd1);
    e1 = 1'b0;
    repeat (5) begin
      tick();
      check("pause_valid", 64'(valid2), 64'd0);
      check("pause_idx", 64'(idx2), 64'd1);
    end
    e1 = 1'b1;
    tick();
    check("resume_hold", 64'(y2), 64'b0010);
    tick();
    check("resume_step", 64'(y2), 64'b0100);

    // Mode switch from SCAN at index 3, then reset mid-scan.
    rst = 1'b1;
    tick();
    rst = 1'b0; div = 8'd0; x = 3'd0;
    repeat (4) tick();
    check("sw_idx", 64'(idx2), 64'd3);
    mode = 1'b0; x = 3'd1;
    tick();
    check("sw_y", 64'(y2), 64'b0010);
    check("sw_wrap", 64'(wrap2), 64'd0);
    mode = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst_y", 64'(y2), 64'd0);
    check("midrst_valid", 64'(valid2), 64'd0);
    rst = 1'b0;

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      e1  = ($urandom_range(0, 9) != 0);
      e0l = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      x   = 3'($urandom);
      div = 8'($urandom_range(0, 3));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
